// File: rtl/fifo_wr_arbiter_ctrl.sv
// Round-robin write-port arbiter and pointer/status controller for a single-clock FIFO_memory.
// Optional almost-full headroom reservation for requester 0 is enabled by FIFO_ARB_ALMOST_FULL_EN.
module fifo_wr_arbiter_ctrl #(
  parameter int DATA_LEN  = 8,
  parameter int ADDR_LEN  = 5,
  parameter int NUM_REQ   = 4,
  parameter int AF_THRESH = 28,
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_LEN-1:0]  req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [DATA_LEN-1:0]          wr_data,
  output logic [ADDR_LEN-1:0]          wr_addr,
  output logic                         wr_en,
  output logic                         wr_full,
  input  logic                         rd_en,
  output logic [ADDR_LEN-1:0]          rd_addr,
  output logic                         rd_empty,
  output logic [ADDR_LEN:0]            fill_count,
`ifdef FIFO_ARB_ALMOST_FULL_EN
  output logic                         almost_full,
`endif
  output logic [GW-1:0]                grant_id
);

  localparam logic [GW-1:0] LAST_RST = GW'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
    $error("fifo_wr_arbiter_ctrl: NUM_REQ must be in 2..16");
  end
  if (AF_THRESH < 1 || AF_THRESH > 2**ADDR_LEN) begin : g_bad_af_thresh
    $error("fifo_wr_arbiter_ctrl: AF_THRESH must be in 1..2**ADDR_LEN");
  end

  logic [ADDR_LEN:0] wr_ptr;
  logic [ADDR_LEN:0] rd_ptr;
  logic [ADDR_LEN:0] wr_ptr_nxt;
  logic [ADDR_LEN:0] rd_ptr_nxt;
  logic [GW-1:0]     last_grant;
  logic [GW-1:0]     win_id;
  logic [GW-1:0]     cand;
  logic              found;
  logic              grant;
  logic              pop;

  // Status flags are held at their reset values while rst is asserted.
  assign wr_addr    = wr_ptr[ADDR_LEN-1:0];
  assign rd_addr    = rd_ptr[ADDR_LEN-1:0];
  assign rd_empty   = rst || (wr_ptr == rd_ptr);
  assign wr_full    = !rst && (wr_ptr[ADDR_LEN] != rd_ptr[ADDR_LEN]) &&
                      (wr_ptr[ADDR_LEN-1:0] == rd_ptr[ADDR_LEN-1:0]);
  assign fill_count = rst ? '0 : (wr_ptr - rd_ptr);

  // Round-robin search starting one past the previous winner.
  always_comb begin
    found  = 1'b0;
    win_id = '0;
    cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GW'((int'(last_grant) + k) % NUM_REQ);
`ifdef FIFO_ARB_ALMOST_FULL_EN
      if (!found && req_valid[cand] && (!almost_full || cand == '0)) begin
`else
      if (!found && req_valid[cand]) begin
`endif
        found  = 1'b1;
        win_id = cand;
      end
    end
  end

  assign grant     = found && !wr_full && !rst;
  assign grant_id  = grant ? win_id : '0;
  assign req_ready = grant ? (NUM_REQ'(1) << win_id) : '0;
  assign wr_en     = grant;
  assign wr_data   = req_data[grant_id*DATA_LEN +: DATA_LEN];

  assign pop        = rd_en && !rd_empty;
  assign wr_ptr_nxt = wr_ptr + {{ADDR_LEN{1'b0}}, wr_en};
  assign rd_ptr_nxt = rd_ptr + {{ADDR_LEN{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      last_grant <= LAST_RST;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      if (wr_en) last_grant <= win_id;
    end
  end

`ifdef FIFO_ARB_ALMOST_FULL_EN
  localparam logic [ADDR_LEN:0] AF_LVL = AF_THRESH[ADDR_LEN:0];

  always_ff @(posedge clk) begin
    if (rst) almost_full <= 1'b0;
    else     almost_full <= ((wr_ptr_nxt - rd_ptr_nxt) >= AF_LVL);
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter_ctrl.sv
// Directed self-checking bench for fifo_wr_arbiter_ctrl with a behavioural FIFO_memory model.
module tb_fifo_wr_arbiter_ctrl;
  localparam int DL = 8;
  localparam int AL = 5;
  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR*DL-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic [DL-1:0]   wr_data;
  logic [AL-1:0]   wr_addr;
  logic            wr_en;
  logic            wr_full;
  logic            rd_en;
  logic [AL-1:0]   rd_addr;
  logic            rd_empty;
  logic [AL:0]     fill_count;
  logic [1:0]      grant_id;
`ifdef FIFO_ARB_ALMOST_FULL_EN
  logic            almost_full;
`endif

  int checks = 0;
  int errors = 0;

  logic [DL-1:0] mem [0:(1<<AL)-1];
  logic [DL-1:0] rd_data;

  always #5 clk = ~clk;

  always @(posedge clk) if (wr_en) mem[wr_addr] <= wr_data;
  assign rd_data = mem[rd_addr];

  fifo_wr_arbiter_ctrl #(.DATA_LEN(DL), .ADDR_LEN(AL), .NUM_REQ(NR), .AF_THRESH(28)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en),
    .wr_full(wr_full), .rd_en(rd_en), .rd_addr(rd_addr), .rd_empty(rd_empty),
    .fill_count(fill_count),
`ifdef FIFO_ARB_ALMOST_FULL_EN
    .almost_full(almost_full),
`endif
    .grant_id(grant_id)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_data(input int i, input logic [DL-1:0] d);
    req_data[i*DL +: DL] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; rd_en = 1'b0;
    tick(); tick();
    rst = 1'b0;
    settle();
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'hF; rd_en = 1'b1; req_data = 32'h44332211;
    tick(); settle();
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", wr_en); end
    checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", rd_empty); end
    checks++; if (wr_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", wr_full); end
    checks++; if (fill_count !== 6'd0) begin errors++; $display("FAIL reset_fill: got %0d expected 0", fill_count); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
`ifdef FIFO_ARB_ALMOST_FULL_EN
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost_full: got %b expected 0", almost_full); end
`endif
    tick();
    rst = 1'b0; req_valid = '0; rd_en = 1'b0;
    settle();
    checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL post_reset_empty: got %b expected 1", rd_empty); end
    checks++; if (wr_addr !== 5'd0 || rd_addr !== 5'd0) begin errors++; $display("FAIL post_reset_addr: got wr %0d rd %0d expected 0 0", wr_addr, rd_addr); end
  endtask

  task automatic test_round_robin();
    logic [1:0] eg;
    logic [3:0] er;
    do_reset();
    req_valid = 4'hF;
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < NR; i++) set_data(i, 8'(n*16 + i));
      settle();
      eg = 2'(n % 4);
      er = 4'(1 << (n % 4));
      checks++; if (grant_id !== eg) begin errors++; $display("FAIL rr_grant_id[%0d]: got %0d expected %0d", n, grant_id, eg); end
      checks++; if (req_ready !== er) begin errors++; $display("FAIL rr_ready[%0d]: got %b expected %b", n, req_ready, er); end
      checks++; if (wr_data !== 8'(n*16 + n%4)) begin errors++; $display("FAIL rr_wr_data[%0d]: got %h expected %h", n, wr_data, 8'(n*16 + n%4)); end
      tick();
    end
    req_valid = '0;
    settle();
    checks++; if (fill_count !== 6'd8) begin errors++; $display("FAIL rr_fill: got %0d expected 8", fill_count); end
    rd_en = 1'b1;
    for (int n = 0; n < 8; n++) begin
      settle();
      checks++; if (rd_addr !== 5'(n)) begin errors++; $display("FAIL rr_rd_addr[%0d]: got %0d expected %0d", n, rd_addr, n); end
      checks++; if (rd_data !== 8'(n*16 + n%4)) begin errors++; $display("FAIL rr_rd_data[%0d]: got %h expected %h", n, rd_data, 8'(n*16 + n%4)); end
      tick();
    end
    rd_en = 1'b0;
    settle();
    checks++; if (rd_empty !== 1'b1 || fill_count !== 6'd0) begin errors++; $display("FAIL rr_drained: got empty %b fill %0d expected 1 0", rd_empty, fill_count); end
  endtask

  task automatic test_full();
    do_reset();
    req_valid = 4'b0100;
    for (int n = 0; n < 32; n++) begin
      set_data(2, 8'(8'hA0 + n));
      settle();
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL full_fill_ready[%0d]: got %b expected 0100", n, req_ready); end
      tick();
    end
    settle();
    checks++; if (wr_full !== 1'b1) begin errors++; $display("FAIL full_flag: got %b expected 1", wr_full); end
    checks++; if (fill_count !== 6'd32) begin errors++; $display("FAIL full_fill: got %0d expected 32", fill_count); end
    checks++; if (req_ready !== 4'b0000 || wr_en !== 1'b0) begin errors++; $display("FAIL full_blocked: got ready %b wr_en %b expected 0000 0", req_ready, wr_en); end
    checks++; if (wr_addr !== 5'd0) begin errors++; $display("FAIL full_wr_addr: got %0d expected 0", wr_addr); end
    tick(); settle();
    checks++; if (fill_count !== 6'd32) begin errors++; $display("FAIL full_hold: got %0d expected 32", fill_count); end
  endtask

  task automatic test_full_push_pop();
    req_valid = 4'b0010; set_data(1, 8'h5B); rd_en = 1'b1;
    settle();
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL fpp_ready_blocked: got %b expected 0000", req_ready); end
    checks++; if (rd_data !== 8'hA0) begin errors++; $display("FAIL fpp_rd_data: got %h expected a0", rd_data); end
    tick();
    rd_en = 1'b0;
    settle();
    checks++; if (fill_count !== 6'd31 || wr_full !== 1'b0) begin errors++; $display("FAIL fpp_after_pop: got fill %0d full %b expected 31 0", fill_count, wr_full); end
    checks++; if (req_ready !== 4'b0010 || grant_id !== 2'd1) begin errors++; $display("FAIL fpp_grant1: got ready %b id %0d expected 0010 1", req_ready, grant_id); end
    tick();
    req_valid = '0;
    settle();
    checks++; if (fill_count !== 6'd32 || wr_full !== 1'b1) begin errors++; $display("FAIL fpp_refull: got fill %0d full %b expected 32 1", fill_count, wr_full); end
    checks++; if (rd_data !== 8'hA1) begin errors++; $display("FAIL fpp_next_word: got %h expected a1", rd_data); end
  endtask

  task automatic test_empty_push_pop();
    do_reset();
    req_valid = 4'b1000; set_data(3, 8'h3C); rd_en = 1'b1;
    settle();
    checks++; if (grant_id !== 2'd3 || wr_data !== 8'h3C) begin errors++; $display("FAIL epp_grant3: got id %0d data %h expected 3 3c", grant_id, wr_data); end
    tick();
    req_valid = '0; rd_en = 1'b0;
    settle();
    checks++; if (rd_addr !== 5'd0) begin errors++; $display("FAIL epp_rd_addr: got %0d expected 0", rd_addr); end
    checks++; if (fill_count !== 6'd1 || rd_empty !== 1'b0) begin errors++; $display("FAIL epp_count: got fill %0d empty %b expected 1 0", fill_count, rd_empty); end
    checks++; if (rd_data !== 8'h3C) begin errors++; $display("FAIL epp_rd_data: got %h expected 3c", rd_data); end
  endtask

  task automatic test_wrap();
    logic [1:0] eg;
    do_reset();
    for (int n = 0; n < 70; n++) begin
      eg = 2'(n % 4);
      req_valid = 4'(1 << (n % 4));
      set_data(n % 4, 8'(n*7 + 3));
      rd_en = 1'b1;
      settle();
      checks++; if (grant_id !== eg) begin errors++; $display("FAIL wrap_grant[%0d]: got %0d expected %0d", n, grant_id, eg); end
      if (n >= 1) begin
        checks++; if (fill_count !== 6'd1) begin errors++; $display("FAIL wrap_fill[%0d]: got %0d expected 1", n, fill_count); end
        checks++; if (rd_data !== 8'((n-1)*7 + 3)) begin errors++; $display("FAIL wrap_rd_data[%0d]: got %h expected %h", n, rd_data, 8'((n-1)*7 + 3)); end
      end
      tick();
    end
    req_valid = '0; rd_en = 1'b0;
    settle();
    checks++; if (rd_addr !== 5'd5 || wr_addr !== 5'd6) begin errors++; $display("FAIL wrap_ptrs: got rd %0d wr %0d expected 5 6", rd_addr, wr_addr); end
    checks++; if (rd_data !== 8'(69*7 + 3)) begin errors++; $display("FAIL wrap_last_word: got %h expected %h", rd_data, 8'(69*7 + 3)); end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    settle();
    checks++; if (rd_empty !== 1'b1 || fill_count !== 6'd0) begin errors++; $display("FAIL wrap_drained: got empty %b fill %0d expected 1 0", rd_empty, fill_count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid = 4'b0011; set_data(0, 8'h11); set_data(1, 8'h22);
    for (int n = 0; n < 12; n++) begin
      settle();
      checks++; if (grant_id !== 2'(n % 2)) begin errors++; $display("FAIL rm_grant[%0d]: got %0d expected %0d", n, grant_id, n % 2); end
      tick();
    end
    settle();
    checks++; if (fill_count !== 6'd12) begin errors++; $display("FAIL rm_fill12: got %0d expected 12", fill_count); end
    rst = 1'b1; req_valid = 4'hF; rd_en = 1'b1;
    settle();
    checks++; if (req_ready !== 4'b0000 || fill_count !== 6'd0) begin errors++; $display("FAIL rm_in_reset: got ready %b fill %0d expected 0000 0", req_ready, fill_count); end
    tick();
    rst = 1'b0;
    settle();
    checks++; if (fill_count !== 6'd0 || rd_empty !== 1'b1) begin errors++; $display("FAIL rm_cleared: got fill %0d empty %b expected 0 1", fill_count, rd_empty); end
    checks++; if (req_ready !== 4'b0001 || grant_id !== 2'd0) begin errors++; $display("FAIL rm_first_grant: got ready %b id %0d expected 0001 0", req_ready, grant_id); end
    tick();
    req_valid = '0; rd_en = 1'b0;
    settle();
    checks++; if (fill_count !== 6'd1 || wr_addr !== 5'd1) begin errors++; $display("FAIL rm_post_push: got fill %0d wr_addr %0d expected 1 1", fill_count, wr_addr); end
  endtask

`ifdef FIFO_ARB_ALMOST_FULL_EN
  task automatic test_almost_full();
    do_reset();
    req_valid = 4'b0010; set_data(1, 8'h77); set_data(0, 8'h99);
    for (int n = 0; n < 28; n++) begin
      settle();
      if (n == 27) begin
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL af_before: got %b expected 0", almost_full); end
      end
      tick();
    end
    settle();
    checks++; if (almost_full !== 1'b1 || fill_count !== 6'd28) begin errors++; $display("FAIL af_set: got af %b fill %0d expected 1 28", almost_full, fill_count); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL af_block_req1: got %b expected 0000", req_ready); end
    req_valid = 4'b0011;
    settle();
    checks++; if (req_ready !== 4'b0001 || grant_id !== 2'd0) begin errors++; $display("FAIL af_req0_only: got ready %b id %0d expected 0001 0", req_ready, grant_id); end
    tick();
    req_valid = '0;
    settle();
    checks++; if (fill_count !== 6'd29 || almost_full !== 1'b1) begin errors++; $display("FAIL af_after: got fill %0d af %b expected 29 1", fill_count, almost_full); end
  endtask
`endif

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; rd_en = 1'b0;
    test_reset();
    test_round_robin();
    test_full();
    test_full_push_pop();
    test_empty_push_pop();
    test_wrap();
    test_reset_mid();
`ifdef FIFO_ARB_ALMOST_FULL_EN
    test_almost_full();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
